// File: rtl/led_rr_scheduler_if.sv
// Request/grant and LED pin bundle between the requesters and the LED scheduler.
// master = requester side (application/bench), slave = the scheduler.
interface led_rr_scheduler_if #(
  parameter int NREQ     = 4,
  parameter int PWM_BITS = 8
);
  logic [NREQ-1:0]          req;
  logic [3*NREQ-1:0]        color;
  logic [PWM_BITS*NREQ-1:0] duty;
  logic [NREQ-1:0]          gnt;
  logic                     busy;
  logic                     ledr;
  logic                     ledg;
  logic                     ledb;

  // Handshake: a requester holds req[i] high for as long as it wants the LED;
  // gnt[i] high means it owns the LED this cycle. Dropping req[i] while granted
  // ends the slot at the next clock edge. color/duty are sampled only on grant.
  modport master (
    output req, color, duty,
    input  gnt, busy, ledr, ledg, ledb
  );

  modport slave (
    input  req, color, duty,
    output gnt, busy, ledr, ledg, ledb
  );
endinterface

// File: rtl/led_rr_scheduler.sv
// Round-robin owner selection for the shared RGB LED with bounded slots and
// per-owner PWM brightness; pins are registered and lag the state by one cycle.
module led_rr_scheduler #(
  parameter int NREQ           = 4,
  parameter int HOLD_CYCLES    = 12000000,
  parameter int PWM_BITS       = 8,
  parameter bit LED_ACTIVE_LOW = 1'b1
) (
  input  logic                CLK,
  input  logic                RSTN,
  led_rr_scheduler_if.slave   bus,
  output logic [1:0]          dbg_state
);

  localparam int IW = $clog2(NREQ);
  localparam int HW = $clog2(HOLD_CYCLES) + 1;
  localparam logic LED_OFF = LED_ACTIVE_LOW ? 1'b1 : 1'b0;
  localparam logic LED_ON  = ~LED_OFF;

  typedef enum logic [1:0] {IDLE = 2'd0, SHOW = 2'd1, GAP = 2'd2} state_e;

  state_e              state_q, state_d;
  logic [NREQ-1:0]     gnt_q, gnt_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [IW-1:0]       owner_q, owner_d;
  logic [HW-1:0]       hold_q, hold_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic [2:0]          color_q, color_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [2:0]          led_q, led_d;

  logic                found;
  logic [IW-1:0]       win;
  logic                pwm_on;

  // First requester at or after ptr, wrapping; ptr itself has top priority.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && bus.req[(int'(ptr_q) + k) % NREQ]) begin
        found = 1'b1;
        win   = IW'((int'(ptr_q) + k) % NREQ);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    hold_d  = hold_q;
    color_d = color_q;
    duty_d  = duty_q;
    pwm_d   = pwm_q + 1'b1;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = SHOW;
          gnt_d   = NREQ'(1) << win;
          owner_d = win;
          color_d = bus.color[3*win +: 3];
          duty_d  = bus.duty[PWM_BITS*win +: PWM_BITS];
          hold_d  = '0;
          ptr_d   = (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;
        end
      end
      SHOW: begin
        hold_d = hold_q + 1'b1;
        if (hold_q == HW'(HOLD_CYCLES - 1) || !bus.req[owner_q]) begin
          state_d = GAP;
          gnt_d   = '0;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    pwm_on   = (state_q == SHOW) && (pwm_q < duty_q);
    led_d[2] = (pwm_on && color_q[2]) ? LED_ON : LED_OFF;
    led_d[1] = (pwm_on && color_q[1]) ? LED_ON : LED_OFF;
    led_d[0] = (pwm_on && color_q[0]) ? LED_ON : LED_OFF;
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      owner_q <= '0;
      hold_q  <= '0;
      pwm_q   <= '0;
      color_q <= '0;
      duty_q  <= '0;
      led_q   <= {3{LED_OFF}};
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      hold_q  <= hold_d;
      pwm_q   <= pwm_d;
      color_q <= color_d;
      duty_q  <= duty_d;
      led_q   <= led_d;
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.busy  = (state_q == SHOW);
  assign bus.ledr  = led_q[2];
  assign bus.ledg  = led_q[1];
  assign bus.ledb  = led_q[0];
  assign dbg_state = state_q;

endmodule

// File: tb/tb_led_rr_scheduler.sv
// Bench for led_rr_scheduler: directed scenarios plus random traffic, checked
// every cycle against a slot-level behavioural model and a grant-order scoreboard.
module tb_led_rr_scheduler;

  localparam int N  = 4;
  localparam int H  = 8;
  localparam int PB = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  led_rr_scheduler_if #(.NREQ(N), .PWM_BITS(PB)) bus ();
  logic [1:0] dbg_state;

  led_rr_scheduler #(
    .NREQ(N), .HOLD_CYCLES(H), .PWM_BITS(PB), .LED_ACTIVE_LOW(1'b1)
  ) dut (
    .CLK(clk), .RSTN(rstn), .bus(bus), .dbg_state(dbg_state)
  );

  // ---------------- checking ----------------
  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Owner is an integer (-1 = nobody), age counts SHOW cycles completed,
  // gap_pending marks the single dark cycle after a slot.
  int         m_owner = -1;
  int         m_age = 0;
  int         m_next = 0;
  int         m_pwm = 0;
  int         m_duty = 0;
  bit         m_gap = 1'b0;
  logic [2:0] m_color = 3'b000;
  logic [2:0] m_led = 3'b111;
  logic [1:0] exp_q[$];
  logic [N-1:0] prev_gnt = '0;

  task automatic model_update();
    bit on;
    bit found;
    int idx;
    on = (m_owner >= 0) && (m_pwm < m_duty);
    if (!rstn) begin
      m_owner = -1; m_age = 0; m_next = 0; m_pwm = 0; m_gap = 1'b0;
      m_led = 3'b111;
      return;
    end
    for (int c = 0; c < 3; c++) m_led[c] = (on && m_color[c]) ? 1'b0 : 1'b1;
    m_pwm = (m_pwm + 1) % (1 << PB);
    if (m_owner >= 0) begin
      m_age++;
      if (m_age == H || !bus.req[m_owner]) begin
        m_owner = -1;
        m_gap   = 1'b1;
      end
    end else if (m_gap) begin
      m_gap = 1'b0;
    end else begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        idx = (m_next + k) % N;
        if (!found && bus.req[idx]) begin
          found   = 1'b1;
          m_owner = idx;
          m_age   = 0;
          m_color = bus.color[3*idx +: 3];
          m_duty  = int'(bus.duty[PB*idx +: PB]);
          m_next  = (idx + 1) % N;
          exp_q.push_back(2'(idx));
        end
      end
    end
  endtask

  task automatic compare_all();
    int obs;
    check("gnt",  bus.gnt,  (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
    check("busy", bus.busy, (m_owner >= 0) ? 32'd1 : 32'd0);
    check("ledr", bus.ledr, m_led[2]);
    check("ledg", bus.ledg, m_led[1]);
    check("ledb", bus.ledb, m_led[0]);
    if (prev_gnt == '0 && bus.gnt != '0) begin
      obs = 0;
      for (int i = 0; i < N; i++) if (bus.gnt[i]) obs = i;
      if (exp_q.size() == 0) check("sb_unexpected_grant", bus.gnt, 32'd0);
      else check("grant_order", obs, exp_q.pop_front());
    end
    prev_gnt = bus.gnt;
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    compare_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_gnt(input logic [N-1:0] mask, input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      step();
      if (bus.gnt == mask) return;
    end
    check("wait_gnt_timeout", 32'd0, 32'd1);
  endtask

  task automatic set_all(input logic [2:0] col, input logic [PB-1:0] dty);
    for (int i = 0; i < N; i++) begin
      bus.color[3*i +: 3]  = col;
      bus.duty[PB*i +: PB] = dty;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rstn      = 1'b0;
    bus.req   = 4'b1111;
    bus.color = 12'($urandom);
    bus.duty  = 8'($urandom);
    run(2);
    check("rst_gnt",  bus.gnt,  32'd0);
    check("rst_busy", bus.busy, 32'd0);
    check("rst_leds", {bus.ledr, bus.ledg, bus.ledb}, 32'h7);

    rstn = 1'b1;
    step();
    check("first_grant", bus.gnt, 32'h1);
    run(20);

    // Single requester: red at half brightness, consecutive slots.
    bus.req = 4'b0000;
    run(12);
    bus.req = 4'b0100;
    set_all(3'b011, 2'd0);
    bus.color[8:6] = 3'b100;
    bus.duty[5:4]  = 2'd2;
    run(40);

    // Round robin over three requesters.
    bus.req = 4'b1011;
    set_all(3'b111, 2'd1);
    run(60);

    // Early release by requester 1; next search starts at index 2.
    bus.req = 4'b0000;
    run(12);
    bus.req = 4'b0010;
    wait_gnt(4'b0010, 40);
    step();
    bus.req = 4'b1101;
    run(3);
    check("early_next_grant", bus.gnt, 32'h4);
    run(20);

    // Duty extremes.
    bus.req = 4'b0001;
    set_all(3'b111, 2'd0);
    run(30);
    set_all(3'b111, 2'd3);
    run(30);

    // Reset in the middle of a slot.
    bus.req = 4'b0001;
    wait_gnt(4'b0001, 40);
    run(3);
    rstn = 1'b0;
    step();
    check("midrst_gnt",  bus.gnt, 32'd0);
    check("midrst_leds", {bus.ledr, bus.ledg, bus.ledb}, 32'h7);
    rstn    = 1'b1;
    bus.req = 4'b1111;
    step();
    check("midrst_regrant", bus.gnt, 32'h1);
    run(10);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(9, 0) == 0) bus.req = 4'($urandom);
      bus.color = 12'($urandom);
      bus.duty  = 8'($urandom);
      rstn = ($urandom_range(199, 0) == 0) ? 1'b0 : 1'b1;
      step();
    end
    rstn = 1'b1;
    bus.req = 4'b0000;
    run(12);

    check("sb_drain", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
